// File: rtl/subleq_pkg.sv
// Shared encodings for the SUBLEQ core and its run controller:
// core FSM states, host command ops and the run-controller FSM.
package subleq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH_A    = 4'd0,
        FETCH_B    = 4'd1,
        FETCH_C    = 4'd2,
        ADDR_A     = 4'd3,
        READ_A     = 4'd4,
        ADDR_B     = 4'd5,
        READ_B     = 4'd6,
        SUBTRACT   = 4'd7,
        WRITE_B    = 4'd8,
        WRITE_WAIT = 4'd9,
        BRANCH_CHK = 4'd10,
        BRANCH     = 4'd11,
        UPDATE_PC  = 4'd12
    } core_state_e;

    typedef enum logic [1:0] {
        CMD_RUN        = 2'd0,
        CMD_HALT       = 2'd1,
        CMD_STEP_INSN  = 2'd2,
        CMD_STEP_CYCLE = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        CTL_IDLE   = 3'd0,
        CTL_RUN    = 3'd1,
        CTL_STEP_I = 3'd2,
        CTL_STEP_C = 3'd3,
        CTL_DRAIN  = 3'd4
    } ctl_state_e;

endpackage

// File: rtl/subleq_run_ctrl_if.sv
// Host command handshake into the run controller; a command is taken
// on any cycle with cmd_valid && cmd_ready.
interface subleq_run_ctrl_if;
    import subleq_pkg::*;

    logic    cmd_valid;
    logic    cmd_ready;
    cmd_op_e cmd_op;

    modport master (output cmd_valid, output cmd_op, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/subleq_prescaler.sv
// Free-running 0..P-1 counter (P = max(prescale,1)); tick is combinational
// from the count, no backpressure; clr holds the count at zero.
module subleq_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;
    logic [PRE_W-1:0] pre_last;

    always_comb begin
        pre_last  = (prescale == '0) ? '0 : prescale - PRE_W'(1);
        // >= so a shrinking prescale wraps immediately instead of running to 2^PRE_W
        tick      = (pre_cnt_q >= pre_last);
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (clr || tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/subleq_run_ctrl.sv
// SUBLEQ execution controller: gates core clk_enable for run/halt/step, counts retires, breakpoints.
// Enable is combinational from registered state; cmd_ready low while stepping/draining; SUBLEQ_CYCLE_CNT_EN adds cycle_count.
module subleq_run_ctrl
    import subleq_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    subleq_run_ctrl_if.slave   cmd,
    input  logic [STATE_W-1:0] core_state,
    input  logic [PRE_W-1:0]   prescale,
    input  logic               bp_en,
    input  logic [CNT_W-1:0]   bp_count,
    output logic               core_clk_enable,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   insn_count,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   cycle_count
);

    ctl_state_e       state_q, state_d;
    logic [CNT_W-1:0] insn_count_q, insn_count_d, insn_next;
    logic             halted_q, halted_d;
    logic             bp_hit_q, bp_hit_d;
    logic             tick, retire, bp_fire, accept;

    subleq_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == CTL_IDLE),
        .prescale (prescale),
        .tick     (tick)
    );

    assign cmd.cmd_ready = (state_q == CTL_IDLE) || (state_q == CTL_RUN);

    always_comb begin
        core_clk_enable = tick && (state_q != CTL_IDLE);
        retire          = core_clk_enable && (core_state == UPDATE_PC);
        insn_next       = insn_count_q + CNT_W'(1);
        // Compare against the post-retire value so a match at RUN time does not fire
        bp_fire         = retire && bp_en && (insn_next == bp_count);
        accept          = cmd.cmd_valid && cmd.cmd_ready;

        state_d = state_q;
        unique case (state_q)
            CTL_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        CMD_RUN:        state_d = CTL_RUN;
                        CMD_STEP_INSN:  state_d = CTL_STEP_I;
                        CMD_STEP_CYCLE: state_d = CTL_STEP_C;
                        default:        state_d = CTL_IDLE;
                    endcase
                end
            end
            CTL_RUN: begin
                if (bp_fire) begin
                    state_d = CTL_IDLE;
                end else if (accept && (cmd.cmd_op == CMD_HALT)) begin
                    state_d = CTL_DRAIN;
                end
            end
            CTL_STEP_I, CTL_DRAIN: begin
                if (retire) begin
                    state_d = CTL_IDLE;
                end
            end
            CTL_STEP_C: begin
                if (core_clk_enable) begin
                    state_d = CTL_IDLE;
                end
            end
            default: state_d = CTL_IDLE;
        endcase

        insn_count_d = retire ? insn_next : insn_count_q;
        bp_hit_d     = bp_fire;
        halted_d     = (state_d == CTL_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CTL_IDLE;
            insn_count_q <= '0;
            halted_q     <= 1'b1;
            bp_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            insn_count_q <= insn_count_d;
            halted_q     <= halted_d;
            bp_hit_q     <= bp_hit_d;
        end
    end

    assign halted     = halted_q;
    assign running    = !halted_q;
    assign insn_count = insn_count_q;
    assign bp_hit     = bp_hit_q;

`ifdef SUBLEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    always_comb begin
        cycle_count_d = core_clk_enable ? cycle_count_q + CNT_W'(1) : cycle_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_subleq_run_ctrl.sv
// Scoreboarded bench for subleq_run_ctrl driving a 13-state core model.
module tb_subleq_run_ctrl;
    import subleq_pkg::*;

    localparam int CNT_W = 8;
    localparam int PRE_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subleq_run_ctrl_if cif();

    logic [3:0]       core_state;
    logic [PRE_W-1:0] prescale;
    logic             bp_en;
    logic [CNT_W-1:0] bp_count;
    logic             en, running, halted, bp_hit;
    logic [CNT_W-1:0] insn_count, cycle_count;

    subleq_run_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd             (cif),
        .core_state      (core_state),
        .prescale        (prescale),
        .bp_en           (bp_en),
        .bp_count        (bp_count),
        .core_clk_enable (en),
        .running         (running),
        .halted          (halted),
        .insn_count      (insn_count),
        .bp_hit          (bp_hit),
        .cycle_count     (cycle_count)
    );

    // Core model: advances one state per enable pulse, 12 wraps to 0.
    always @(posedge clk) begin
        if (rst) core_state <= 4'd0;
        else if (en) core_state <= (core_state == 4'd12) ? 4'd0 : core_state + 4'd1;
    end

    typedef struct {
        int pulses;
        int insn;
        int bps;
        int cs;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: accumulates one episode (command accept -> return to halted) and scores it.
    int   m_pulses = 0;
    int   m_bps    = 0;
    int   m_gap    = 0;
    int   m_min    = 1 << 30;
    int   m_max    = 0;
    int   m_ep     = 0;
    logic prev_halted = 1'b1;
    exp_t e;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_pulses = 0; m_bps = 0; m_gap = 0; m_min = 1 << 30; m_max = 0;
            prev_halted = 1'b1;
        end else begin
            m_gap++;
            if (en) begin
                m_pulses++;
                if (m_gap < m_min) m_min = m_gap;
                if (m_gap > m_max) m_max = m_gap;
                m_gap = 0;
            end
            if (bp_hit) m_bps++;
            if (cif.cmd_valid && cif.cmd_ready && halted) m_gap = 0;
            if (halted && !prev_halted) begin
                m_ep++;
                check($sformatf("ep%0d_expected_present", m_ep), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("ep%0d_pulses", m_ep), m_pulses, e.pulses);
                    check($sformatf("ep%0d_insn_count", m_ep), insn_count, e.insn);
                    check($sformatf("ep%0d_bp_hit_cycles", m_ep), m_bps, e.bps);
                    check($sformatf("ep%0d_core_state", m_ep), core_state, e.cs);
                    check($sformatf("ep%0d_min_gap", m_ep), m_min, e.gap);
                    check($sformatf("ep%0d_max_gap", m_ep), m_max, e.gap);
                end
                m_pulses = 0; m_bps = 0; m_min = 1 << 30; m_max = 0;
            end
            prev_halted = halted;
        end
    end

    task automatic expect_halt(input int p, input int insn, input int bps, input int cs, input int gap);
        exp_t x;
        x = '{p, insn, bps, cs, gap};
        exp_q.push_back(x);
    endtask

    task automatic send(input cmd_op_e op);
        int n = 0;
        while (!cif.cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready_before_send", cif.cmd_ready, 1);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_halted_in_budget"}, halted, 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string name);
        check({name, "_halted"}, halted, 1);
        check({name, "_running"}, running, 0);
        check({name, "_enable"}, en, 0);
        check({name, "_insn_count"}, insn_count, 0);
        check({name, "_cmd_ready"}, cif.cmd_ready, 1);
        check({name, "_bp_hit"}, bp_hit, 0);
        check({name, "_cycle_count"}, cycle_count, 0);
    endtask

    initial begin
        int n;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = CMD_RUN;
        prescale      = 16'd1;
        bp_en         = 1'b0;
        bp_count      = '0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single instruction at full speed
        expect_halt(13, 1, 0, 0, 1);
        send(CMD_STEP_INSN);
        check("step_insn_ready_low", cif.cmd_ready, 0);
        check("step_insn_running", running, 1);
        wait_idle("step_insn", 100);

        // RUN at prescale 4, HALT mid-instruction drains to the retire
        prescale = 16'd4;
        expect_halt(26, 3, 0, 0, 4);
        send(CMD_RUN);
        n = 0;
        while (!(insn_count == 8'd2 && core_state == 4'd5) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check("reached_state5", (insn_count == 8'd2 && core_state == 4'd5), 1);
        send(CMD_HALT);
        check("drain_ready_low", cif.cmd_ready, 0);
        wait_idle("drain", 200);

        // Cycle steps then finish the partial instruction
        prescale = 16'd0;
        for (int i = 1; i <= 3; i++) begin
            expect_halt(1, 3, 0, i, 1);
            send(CMD_STEP_CYCLE);
            wait_idle("step_cycle", 20);
        end
        expect_halt(10, 4, 0, 0, 1);
        send(CMD_STEP_INSN);
        wait_idle("step_insn_partial", 60);

        // Breakpoint at 3 from reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prescale = 16'd1;
        bp_en    = 1'b1;
        bp_count = 8'd3;
        expect_halt(39, 3, 1, 0, 1);
        send(CMD_RUN);
        wait_idle("bp3", 100);
`ifdef SUBLEQ_CYCLE_CNT_EN
        check("cycle_count_bp3", cycle_count, 39);
`else
        check("cycle_count_bp3", cycle_count, 0);
`endif

        // Breakpoint at 250, then step across the counter wrap
        bp_count = 8'd250;
        expect_halt(3211, 250, 1, 0, 1);
        send(CMD_RUN);
        wait_idle("bp250", 4000);
        for (int k = 1; k <= 6; k++) begin
            expect_halt(13, (250 + k) % 256, 0, 0, 1);
            send(CMD_STEP_INSN);
            wait_idle("step_wrap", 60);
        end
        check("insn_count_wrapped", insn_count, 0);

        // bp_count equal to insn_count at RUN: fires only after a full wrap
        bp_count = 8'd0;
        expect_halt(3328, 0, 1, 0, 1);
        send(CMD_RUN);
        wait_idle("bp_full_wrap", 4000);

        // Reset in the middle of a RUN
        bp_en    = 1'b0;
        prescale = 16'd4;
        send(CMD_RUN);
        repeat (30) @(posedge clk);
        #1;
        check("pre_reset_running", running, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_checks("mid_run_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
